io_bus_ctrl: RTL and testbench

Parametrised successor to the fixed IO address decoder. It decodes CPU IO accesses onto N_SLAVES peripheral channels and supports per-slave wait states through an ack handshake. A per-access timeout and an error flag cover slaves that never respond. The block sits between the CPU IO port and the peripheral set (LEDS, UART, I2C, QCON, HP, ...) and stalls the CPU until each access completes.

---
 rtl/io_bus_ctrl.sv | 138 +++++++++++++
 tb/tb_io_bus_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_ctrl.sv
// CPU IO bus controller: decodes IO accesses onto N_SLAVES channels with
// per-slave wait states (ack handshake), access timeout and error counting.
module io_bus_ctrl #(
  parameter int                  ADDR_W    = 14,
  parameter int                  N_SLAVES  = 8,
  parameter int                  SEL_LSB   = 4,
  parameter int                  SEL_W     = 3,
  parameter logic [N_SLAVES-1:0] FIXED_ACK = {N_SLAVES{1'b1}},
  parameter int                  TIMEOUT   = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   DBE,
  input  logic                   IO_REQ,
  input  logic                   IO_WE,
  input  logic                   IO_RE,
  input  logic [ADDR_W-1:0]      IO_ADDR,
  input  logic [31:0]            IO_WD,
  output logic [31:0]            IO_RD,
  output logic                   IO_STALL,
  output logic                   IO_ERR,
  output logic [7:0]             ERR_CNT,
  output logic [N_SLAVES-1:0]    SL_SEL,
  output logic [N_SLAVES-1:0]    SL_WE,
  output logic [N_SLAVES-1:0]    SL_RE,
  output logic [SEL_LSB-1:0]     SL_A,
  output logic [31:0]            SL_WD,
  input  logic [N_SLAVES*32-1:0] SL_RD,
  input  logic [N_SLAVES-1:0]    SL_ACK
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [SEL_W-1:0]  idx;
  logic              is_read;
  logic [CNT_W-1:0]  tmo_cnt;

  logic              accept;
  logic [SEL_W-1:0]  req_idx;
  logic [N_SLAVES-1:0] req_onehot;
  logic              cur_mapped;
  logic              cur_ack;
  logic [31:0]       cur_rd;

  assign accept   = (state == IDLE) && IO_REQ && !DBE && (IO_WE || IO_RE);
  assign IO_STALL = accept || (state == ACCESS);
  assign req_idx  = IO_ADDR[SEL_LSB+SEL_W-1:SEL_LSB];

  // Address bits above the select field are mirrored, hence deliberately unused.
  generate
    if (ADDR_W > SEL_LSB + SEL_W) begin : g_mirror
      logic unused_high;
      assign unused_high = ^IO_ADDR[ADDR_W-1:SEL_LSB+SEL_W];
    end
  endgenerate

  // Decode of the incoming request and of the captured slave index. An index
  // with no matching channel leaves cur_mapped low, which marks it unmapped.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    req_onehot = '0;
    cur_mapped = 1'b0;
    cur_ack    = 1'b0;
    cur_rd     = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (req_idx == SEL_W'(i)) req_onehot[i] = 1'b1;
      if (idx == SEL_W'(i)) begin
        cur_mapped = 1'b1;
        cur_ack    = FIXED_ACK[i] | SL_ACK[i];
        cur_rd     = SL_RD[32*i +: 32];
      end
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      idx     <= '0;
      is_read <= 1'b0;
      tmo_cnt <= '0;
      IO_RD   <= '0;
      IO_ERR  <= 1'b0;
      ERR_CNT <= '0;
      SL_SEL  <= '0;
      SL_WE   <= '0;
      SL_RE   <= '0;
      SL_A    <= '0;
      SL_WD   <= '0;
    end else begin
      SL_WE <= '0;
      SL_RE <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= ACCESS;
            idx     <= req_idx;
            is_read <= !IO_WE;
            tmo_cnt <= '0;
            SL_A    <= IO_ADDR[SEL_LSB-1:0];
            SL_WD   <= IO_WD;
            SL_SEL  <= req_onehot;
            // Write wins over read; strobes fire once in the first ACCESS cycle.
            if (IO_WE) SL_WE <= req_onehot;
            else       SL_RE <= req_onehot;
          end
        end
        ACCESS: begin
          if (cur_mapped && cur_ack) begin
            state  <= DONE;
            SL_SEL <= '0;
            IO_ERR <= 1'b0;
            if (is_read) IO_RD <= cur_rd;
          end else if (!cur_mapped || tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
            state  <= DONE;
            SL_SEL <= '0;
            IO_ERR <= 1'b1;
            IO_RD  <= '0;
            if (ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          IO_ERR <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Self-checking bench for io_bus_ctrl: table of accesses with a scoreboard of
// expected completions, plus hand sequences for reset, DBE and back-to-back.
module tb_io_bus_ctrl;

  localparam int N   = 5;
  localparam logic [N-1:0] FIXED = 5'b11001;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          DBE = 1'b0;
  logic          IO_REQ = 1'b0;
  logic          IO_WE = 1'b0;
  logic          IO_RE = 1'b0;
  logic [13:0]   IO_ADDR = '0;
  logic [31:0]   IO_WD = '0;
  logic [31:0]   IO_RD;
  logic          IO_STALL;
  logic          IO_ERR;
  logic [7:0]    ERR_CNT;
  logic [N-1:0]  SL_SEL, SL_WE, SL_RE;
  logic [3:0]    SL_A;
  logic [31:0]   SL_WD;
  logic [N*32-1:0] SL_RD = '0;
  logic [N-1:0]  SL_ACK = '0;

  io_bus_ctrl #(.N_SLAVES(N), .FIXED_ACK(FIXED)) dut (
    .CLK(CLK), .RESET(RESET), .DBE(DBE), .IO_REQ(IO_REQ), .IO_WE(IO_WE),
    .IO_RE(IO_RE), .IO_ADDR(IO_ADDR), .IO_WD(IO_WD), .IO_RD(IO_RD),
    .IO_STALL(IO_STALL), .IO_ERR(IO_ERR), .ERR_CNT(ERR_CNT), .SL_SEL(SL_SEL),
    .SL_WE(SL_WE), .SL_RE(SL_RE), .SL_A(SL_A), .SL_WD(SL_WD), .SL_RD(SL_RD),
    .SL_ACK(SL_ACK)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we, re;
    logic [13:0] addr;
    logic [31:0] wd;
    int          ack_at;   // ACCESS cycle (1-based) the slave acks; 0 = never
    logic [31:0] srd;
    logic        scramble; // change inputs after acceptance
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_ncyc;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          ncyc;
    int          we_p, re_p;
    logic [7:0]  ecnt;
  } exp_t;

  exp_t sb[$];
  logic [7:0] ecnt_model = 8'd0;

  task automatic access(input vec_t v);
    int    idx, n_acc, we_c, re_c, sel_c, stray;
    bit    mapped, done;
    exp_t  e;
    idx    = int'(v.addr[6:4]);
    mapped = idx < N;
    if (v.exp_err) ecnt_model = (ecnt_model == 8'hFF) ? 8'hFF : ecnt_model + 8'd1;
    e.rd = v.exp_rd; e.err = v.exp_err; e.ncyc = v.exp_ncyc;
    e.we_p = (mapped && v.we) ? 1 : 0;
    e.re_p = (mapped && !v.we && v.re) ? 1 : 0;
    e.ecnt = ecnt_model;
    sb.push_back(e);

    @(negedge CLK);
    for (int i = 0; i < N; i++) if (i == idx) SL_RD[32*i +: 32] = v.srd;
    IO_REQ = 1'b1; IO_WE = v.we; IO_RE = v.re; IO_ADDR = v.addr; IO_WD = v.wd; DBE = 1'b0;
    #1;
    check("accept_stall", {31'b0, IO_STALL}, 32'd1);
    n_acc = 0; we_c = 0; re_c = 0; sel_c = 0; stray = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge CLK);
      SL_ACK = '0;
      if (!IO_STALL) begin
        done = 1;
      end else begin
        n_acc++;
        for (int i = 0; i < N; i++) begin
          if (i == idx) begin
            we_c  += int'(SL_WE[i]);
            re_c  += int'(SL_RE[i]);
            sel_c += int'(SL_SEL[i]);
          end else begin
            stray += int'(SL_WE[i]) + int'(SL_RE[i]) + int'(SL_SEL[i]);
          end
        end
        if (n_acc == 1 && mapped) begin
          check("sl_a", {28'b0, SL_A}, {28'b0, v.addr[3:0]});
          check("sl_wd", SL_WD, v.wd);
        end
        if (n_acc == 1 && v.scramble) begin
          IO_ADDR = ~v.addr; IO_WE = ~v.we; IO_RE = ~v.re; DBE = 1'b1;
        end
        if (v.ack_at == n_acc && mapped)
          for (int i = 0; i < N; i++) if (i == idx) SL_ACK[i] = 1'b1;
      end
    end
    if (!done) check("done_reached", {31'b0, IO_STALL}, 32'd0);
    e = sb.pop_front();
    check("io_rd", IO_RD, e.rd);
    check("io_err", {31'b0, IO_ERR}, {31'b0, e.err});
    check("err_cnt", {24'b0, ERR_CNT}, {24'b0, e.ecnt});
    check("access_cycles", n_acc, e.ncyc);
    check("we_pulses", we_c, e.we_p);
    check("re_pulses", re_c, e.re_p);
    check("sel_cycles", sel_c, mapped ? e.ncyc : 0);
    check("stray_strobes", stray, 0);
    IO_REQ = 1'b0; DBE = 1'b0; SL_RD = '0;
    @(negedge CLK);
    check("io_err_cleared", {31'b0, IO_ERR}, 32'd0);
    check("io_rd_held", IO_RD, e.rd);
  endtask

  vec_t tbl[11];
  vec_t sat;
  logic [5:0] stall_bits;
  int we_cnt;

  initial begin
    tbl[0]  = '{1, 0, 14'h005,  32'h000000A5, 0,  32'h0,        0, 32'h00000000, 0, 1};
    tbl[1]  = '{0, 1, 14'h010,  32'h0,        3,  32'h12345678, 1, 32'h12345678, 0, 3};
    tbl[2]  = '{1, 0, 14'h3013, 32'hDEADBEEF, 1,  32'h0,        0, 32'h12345678, 0, 1};
    tbl[3]  = '{0, 1, 14'h020,  32'h0,        0,  32'h99999999, 1, 32'h00000000, 1, 16};
    tbl[4]  = '{0, 1, 14'h020,  32'h0,        0,  32'h88888888, 0, 32'h00000000, 1, 16};
    tbl[5]  = '{0, 1, 14'h030,  32'h0,        0,  32'hCAFEF00D, 0, 32'hCAFEF00D, 0, 1};
    tbl[6]  = '{0, 1, 14'h070,  32'h0,        1,  32'h0,        0, 32'h00000000, 1, 1};
    tbl[7]  = '{0, 1, 14'h021,  32'h0,        16, 32'h0BADC0DE, 0, 32'h0BADC0DE, 0, 16};
    tbl[8]  = '{0, 1, 14'h048,  32'h0,        0,  32'h44444444, 0, 32'h44444444, 0, 1};
    tbl[9]  = '{1, 1, 14'h000,  32'h00000055, 0,  32'h0,        0, 32'h44444444, 0, 1};
    tbl[10] = '{1, 0, 14'h050,  32'h00000011, 0,  32'h0,        0, 32'h00000000, 1, 1};

    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_io_rd", IO_RD, 32'd0);
    check("rst_io_err", {31'b0, IO_ERR}, 32'd0);
    check("rst_err_cnt", {24'b0, ERR_CNT}, 32'd0);
    check("rst_sel", {27'b0, SL_SEL | SL_WE | SL_RE}, 32'd0);
    check("rst_sl_a_wd", SL_WD | {28'b0, SL_A}, 32'd0);
    check("rst_stall", {31'b0, IO_STALL}, 32'd0);

    // Reset in the 2nd ACCESS cycle of a waiting read on slave 1.
    IO_REQ = 1'b1; IO_RE = 1'b1; IO_WE = 1'b0; IO_ADDR = 14'h010;
    @(negedge CLK);
    check("mid_sel_1", {27'b0, SL_SEL}, 32'h2);
    check("mid_re_1", {27'b0, SL_RE}, 32'h2);
    @(negedge CLK);
    check("mid_sel_2", {27'b0, SL_SEL}, 32'h2);
    check("mid_re_2", {27'b0, SL_RE}, 32'h0);
    RESET = 1'b1; IO_REQ = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    check("mid_rst_sel", {27'b0, SL_SEL | SL_RE}, 32'h0);
    check("mid_rst_stall", {31'b0, IO_STALL}, 32'd0);
    check("mid_rst_err_cnt", {24'b0, ERR_CNT}, 32'd0);
    @(negedge CLK);
    check("mid_rst_err", {31'b0, IO_ERR}, 32'd0);
    check("mid_rst_idle", {31'b0, IO_STALL}, 32'd0);

    for (int k = 0; k < 11; k++) access(tbl[k]);

    // DBE suppresses acceptance.
    @(negedge CLK);
    IO_REQ = 1'b1; DBE = 1'b1; IO_WE = 1'b1; IO_RE = 1'b0; IO_ADDR = 14'h000;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("dbe_stall", {31'b0, IO_STALL}, 32'd0);
      @(negedge CLK);
      check("dbe_strobes", {27'b0, SL_SEL | SL_WE | SL_RE}, 32'd0);
    end
    IO_REQ = 1'b0; DBE = 1'b0;

    // Request held through DONE: exactly one write strobe per access.
    @(negedge CLK);
    IO_REQ = 1'b1; IO_WE = 1'b1; IO_RE = 1'b0; IO_ADDR = 14'h001; IO_WD = 32'h77;
    we_cnt = 0;
    #1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge CLK);
      stall_bits[k] = IO_STALL;
      we_cnt += int'(SL_WE[0]);
    end
    IO_REQ = 1'b0;
    check("b2b_stall_pattern", {26'b0, stall_bits}, 32'b011011);
    check("b2b_we_pulses", we_cnt, 2);
    @(negedge CLK);
    check("b2b_idle", {26'b0, IO_STALL, SL_WE}, 32'd0);

    // Error counter saturation with unmapped accesses.
    sat = '{0, 1, 14'h060, 32'h0, 0, 32'h0, 0, 32'h0, 1, 1};
    for (int k = 0; k < 256; k++) access(sat);
    check("err_cnt_saturated", {24'b0, ERR_CNT}, 32'd255);
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
